regfile_datapath: RTL

- Parametrised successor to the fixed 16x16 register datapath.
- Contains a register file of NUM_REGS x DATA_W. Register 0 is the program counter.
- Drives operands to an external combinational ALU and writes results back.
- Performs loads and stores through a valid/ready memory port with two spaces (main memory, stack). A writeback FSM stalls further commands while a memory transaction is outstanding.

---
 rtl/regfile_datapath_pkg.sv | 28 ++
 rtl/regfile_read_port.sv | 29 ++
 rtl/regfile_datapath.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_datapath_pkg
// Description : Shared command/state encodings and constants for the
//               register-file datapath.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package regfile_datapath_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_ALU   = 2'b01,
        CMD_LOAD  = 2'b10,
        CMD_STORE = 2'b11
    } cmd_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } fsm_state_e;

    localparam int   PC_INDEX    = 0;
    localparam logic SPACE_MEM   = 1'b0;
    localparam logic SPACE_STACK = 1'b1;

endpackage
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_port
// Description : Selects one register from the flattened register vector;
//               out-of-range selects read as zero.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module regfile_read_port #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic [NUM_REGS*DATA_W-1:0] i_regs,
    input  logic [SEL_W-1:0]           i_sel,
    output logic [DATA_W-1:0]          o_data
);

    // Equality scan keeps selects beyond NUM_REGS from indexing past the vector.
    always_comb begin
        o_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_sel == SEL_W'(i)) begin
                o_data = i_regs[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_datapath.sv
`default_nettype none
// ============================================================================
// Module      : regfile_datapath
// Description : Register file with PC in register 0, external-ALU operand
//               drive/writeback and a valid/ready load/store port.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module regfile_datapath
    import regfile_datapath_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int SEL_W    = $clog2(NUM_REGS),
    parameter int ADDR_W   = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_kind,
    input  logic                       cmd_space,
    input  logic                       cmd_pc_inc,
    input  logic [SEL_W-1:0]           cmd_a_sel,
    input  logic [SEL_W-1:0]           cmd_b_sel,
    input  logic [SEL_W-1:0]           cmd_rd_sel,
    input  logic                       cmd_a_imm_en,
    input  logic                       cmd_b_imm_en,
    input  logic [DATA_W-1:0]          cmd_a_imm,
    input  logic [DATA_W-1:0]          cmd_b_imm,
    output logic [DATA_W-1:0]          alu_a,
    output logic [DATA_W-1:0]          alu_b,
    input  logic [DATA_W-1:0]          alu_result,
    input  logic                       alu_ofl,
    input  logic                       alu_err,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic                       mem_req_we,
    output logic                       mem_req_space,
    output logic [ADDR_W-1:0]          mem_req_addr,
    output logic [DATA_W-1:0]          mem_req_wdata,
    input  logic                       mem_rsp_valid,
    input  logic [DATA_W-1:0]          mem_rsp_data,
    output logic                       busy,
    output logic [DATA_W-1:0]          pc,
    output logic [NUM_REGS*DATA_W-1:0] registers,
    output logic [NUM_REGS-1:0]        overflow,
    output logic [NUM_REGS-1:0]        errorbit,
    output logic [NUM_REGS-1:0]        zeroflag,
    output logic [NUM_REGS-1:0]        signflag
);

    fsm_state_e          r_state;
    logic                r_req_valid;
    logic                r_req_we;
    logic                r_req_space;
    logic [ADDR_W-1:0]   r_req_addr;
    logic [DATA_W-1:0]   r_req_wdata;
    logic [SEL_W-1:0]    r_rd;

    logic [NUM_REGS*DATA_W-1:0] w_regs_flat;
    logic [DATA_W-1:0]   w_rd_a;
    logic [DATA_W-1:0]   w_rd_b;
    logic [DATA_W-1:0]   w_rd_st;
    logic                w_accept;
    logic                w_alu_wr;
    logic                w_rsp_wr;
    logic                w_pc_inc;
    logic                w_is_load;
    logic                w_is_store;
    logic [DATA_W-1:0]   w_wr_data;
    logic                w_wr_ofl;
    logic                w_wr_err;

    assign cmd_ready  = (r_state == ST_IDLE) && !reset;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_is_load  = (cmd_kind == CMD_LOAD);
    assign w_is_store = (cmd_kind == CMD_STORE);
    assign w_alu_wr   = w_accept && (cmd_kind == CMD_ALU);
    assign w_pc_inc   = w_accept && cmd_pc_inc;
    assign w_rsp_wr   = (r_state == ST_RSP) && mem_rsp_valid;

    // ALU writeback and load response never coincide: one needs IDLE, the other RSP.
    assign w_wr_data = w_alu_wr ? alu_result : mem_rsp_data;
    assign w_wr_ofl  = w_alu_wr && alu_ofl;
    assign w_wr_err  = w_alu_wr && alu_err;

    regfile_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_port_a (
        .i_regs (w_regs_flat),
        .i_sel  (cmd_a_sel),
        .o_data (w_rd_a)
    );

    regfile_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_port_b (
        .i_regs (w_regs_flat),
        .i_sel  (cmd_b_sel),
        .o_data (w_rd_b)
    );

    regfile_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_port_st (
        .i_regs (w_regs_flat),
        .i_sel  (cmd_rd_sel),
        .o_data (w_rd_st)
    );

    assign alu_a = cmd_a_imm_en ? cmd_a_imm : w_rd_a;
    assign alu_b = cmd_b_imm_en ? cmd_b_imm : w_rd_b;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [DATA_W-1:0] r_val;
        logic              r_ovf;
        logic              r_err;
        logic              w_wr_en;

        assign w_wr_en = (w_alu_wr && (cmd_rd_sel == SEL_W'(gi))) ||
                         (w_rsp_wr && (r_rd == SEL_W'(gi)));

        // An explicit write to the PC takes priority over its increment.
        always_ff @(posedge clock) begin
            if (reset) begin
                r_val <= '0;
                r_ovf <= 1'b0;
                r_err <= 1'b0;
            end else if (w_wr_en) begin
                r_val <= w_wr_data;
                r_ovf <= w_wr_ofl;
                r_err <= w_wr_err;
            end else if ((gi == PC_INDEX) && w_pc_inc) begin
                r_val <= r_val + DATA_W'(1);
            end
        end

        assign w_regs_flat[gi*DATA_W +: DATA_W] = r_val;
        assign overflow[gi] = r_ovf;
        assign errorbit[gi] = r_err;
        assign zeroflag[gi] = (r_val == '0);
        assign signflag[gi] = r_val[DATA_W-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_req_valid <= 1'b0;
            r_req_we    <= 1'b0;
            r_req_space <= SPACE_MEM;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_rd        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && (w_is_load || w_is_store)) begin
                        r_state     <= ST_REQ;
                        r_req_valid <= 1'b1;
                        r_req_we    <= w_is_store;
                        r_req_space <= cmd_space ? SPACE_STACK : SPACE_MEM;
                        r_req_addr  <= alu_result[ADDR_W-1:0];
                        if (w_is_store) begin
                            r_req_wdata <= w_rd_st;
                        end else begin
                            r_rd <= cmd_rd_sel;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= r_req_we ? ST_IDLE : ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (mem_rsp_valid) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_valid = r_req_valid;
    assign mem_req_we    = r_req_we;
    assign mem_req_space = r_req_space;
    assign mem_req_addr  = r_req_addr;
    assign mem_req_wdata = r_req_wdata;
    assign busy          = (r_state != ST_IDLE);
    assign pc            = w_regs_flat[PC_INDEX*DATA_W +: DATA_W];
    assign registers     = w_regs_flat;

endmodule
`default_nettype wire
